// File: rtl/updown_counter_mod.sv
// Up/down counter with runtime modulus, wrap/saturate boundary handling,
// variable step, parallel load, enable prescaler and terminal-count flags.
module updown_counter_mod #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  count,
    output logic              tc_pulse,
    output logic              ovf_sticky,
    output logic              at_max,
    output logic              at_min
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

    logic [PS_W-1:0]  ps_q;
    logic             cnt_evt;
    logic             bnd;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   max_x;
    logic [WIDTH:0]   step_x;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_clamped;

    assign cnt_evt      = en && !load && (ps_q == PS_LAST);
    assign cnt_x        = {1'b0, count};
    assign max_x        = {1'b0, max_val};
    assign step_x       = (WIDTH+1)'(step);
    assign load_clamped = (load_val > max_val) ? max_val : load_val;

    // One extra bit of headroom keeps count+step and count+max+1 exact.
    always_comb begin
        next_count = count;
        bnd        = 1'b0;
        if (step_x != '0) begin
            if (cnt_x > max_x) begin
                bnd        = 1'b1;
                next_count = mode ? max_val : '0;
            end else if (up_down) begin
                if (cnt_x + step_x <= max_x) begin
                    next_count = WIDTH'(cnt_x + step_x);
                end else begin
                    bnd        = 1'b1;
                    next_count = mode ? max_val : WIDTH'(cnt_x + step_x - max_x - ONE_X);
                end
            end else begin
                if (step_x <= cnt_x) begin
                    next_count = WIDTH'(cnt_x - step_x);
                end else begin
                    bnd        = 1'b1;
                    next_count = mode ? '0 : WIDTH'(cnt_x + max_x + ONE_X - step_x);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            ps_q       <= '0;
            tc_pulse   <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (load) begin
            count    <= load_clamped;
            ps_q     <= '0;
            tc_pulse <= 1'b0;
            if (clr_ovf)
                ovf_sticky <= 1'b0;
        end else begin
            if (en)
                ps_q <= (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
            tc_pulse <= cnt_evt && bnd;
            if (cnt_evt)
                count <= next_count;
            // A boundary in the same cycle takes precedence over the clear.
            if (cnt_evt && bnd)
                ovf_sticky <= 1'b1;
            else if (clr_ovf)
                ovf_sticky <= 1'b0;
        end
    end

    assign at_max = (count == max_val);
    assign at_min = (count == '0);

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised up/down counter with runtime modulus, wrap or saturate mode, variable step, parallel load, an enable prescaler and terminal-count reporting. It replaces the fixed-width, step-of-one counter in timer, event-counting and address-sequencing paths that need a non-power-of-two range, boundary flags or a slower count rate.

## Interface
- WIDTH, 8: counter width in bits (≥2).
- STEP_W, 4: width of the step input (≤ WIDTH).
- PRESCALE, 1: enabled cycles per count event (≥1; 1 = every enabled cycle).

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; prescaler advances only while high.
- up_down  in  1  1 = count up, 0 = count down.
- step  in  STEP_W  increment/decrement magnitude per count event.
- max_val  in  WIDTH  top of range; counter range is 0..max_val.
- mode  in  1  0 = wrap (modulo max_val+1), 1 = saturate.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value for load.
- clr_ovf  in  1  clears ovf_sticky.
- count  out  WIDTH  registered counter value.
- tc_pulse  out  1  registered one-cycle boundary pulse.
- ovf_sticky  out  1  registered sticky boundary flag.
- at_max  out  1  combinational, count == max_val.
- at_min  out  1  combinational, count == 0.

## Operation
- Priority per cycle: rst > load > count event > hold.
- rst: count=0, tc_pulse=0, ovf_sticky=0, prescaler=0.
- load: count = min(load_val, max_val); prescaler cleared; tc_pulse=0; no count event that cycle.
- Prescaler: counts 0..PRESCALE-1 on cycles with en=1 and no load; holds while en=0. Count event fires on an enabled cycle where prescaler == PRESCALE-1, and prescaler returns to 0. PRESCALE=1: every enabled cycle is an event.
- Arithmetic in WIDTH+1 bits; step zero-extended.
- Up event: if count > max_val (max_val lowered at runtime), out-of-range case below. Else if count+step ≤ max_val, count += step. Else boundary: wrap → count+step−(max_val+1); saturate → max_val.
- Down event: if count > max_val, out-of-range case. Else if step ≤ count, count −= step. Else boundary: wrap → count+(max_val+1)−step; saturate → 0.
- Out-of-range event: count = max_val (saturate) or 0 (wrap); counts as a boundary.
- step=0 event: count unchanged, no boundary.
- Saturate at limit with step>0 in the same direction: count holds and it is a boundary every event.
- Boundary: tc_pulse=1 for that one cycle; ovf_sticky set. All other cycles tc_pulse=0.
- ovf_sticky: cleared by clr_ovf; a set in the same cycle wins over clr_ovf.
- Contract: in wrap mode step ≤ max_val+1; larger steps are out of contract and unchecked.
- max_val=0: count pinned at 0; every event with step>0 is a boundary.

## Timing
- count, tc_pulse and ovf_sticky update on the edge that samples the event. tc_pulse is high in the same cycle the wrapped or clamped count is first visible.
- Load is visible on count one cycle after load is sampled. at_max/at_min follow count combinationally with zero latency.
- rst mid-prescale or mid-boundary discards the pending state. The first event after rst deasserts occurs on the PRESCALE-th enabled cycle.
- No combinational path from inputs to count, tc_pulse or ovf_sticky.

## Test plan
- WIDTH=8, PRESCALE=1, max_val=9, step=3, mode=0, up, en=1 from reset → count 0,3,6,9,2; tc_pulse only with 2; ovf_sticky=1 afterwards.
- Same, mode=1 → 0,3,6,9,9,9; tc_pulse on each event at 9; at_max=1 from count=9.
- Down, mode=0, load_val=1, max_val=9, step=3 → count 1 then 8 with tc_pulse; mode=1 → 0 with tc_pulse, at_min=1.
- PRESCALE=3, step=1, en=1 → count increments every 3rd cycle. en low for 2 cycles mid-prescale delays the next increment by exactly 2 cycles. load at prescaler=1 restarts the 3-cycle spacing.
- load_val=200 with max_val=9 → count=9. Then max_val lowered to 5 with count=9 and an up event → count=5 (saturate) or 0 (wrap), with tc_pulse.
- clr_ovf and a boundary in the same cycle → ovf_sticky stays 1. clr_ovf alone → 0 next cycle. rst asserted mid-run → all registered outputs 0 next cycle.
